// File: rtl/hbm_pkg.sv
// Shared types and default sizing for the HBM scrub scheduler slice.
package hbm_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int CH_W_DEF   = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int SPARE_CH   = NUM_CH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_SWAP  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [CH_W_DEF-1:0]   ch;
    logic [ADDR_W_DEF-1:0] addr;
  } scrub_req_t;

endpackage

// File: rtl/hbm_err_tracker.sv
// Per-channel saturating ECC error counters with threshold detection.
module hbm_err_tracker #(
  parameter int NUM_CH     = 8,
  parameter int CH_W       = 4,
  parameter int CNT_W      = 8,
  parameter int ERR_THRESH = 4
) (
  input  logic            clk_2gt,
  input  logic            rst,
  input  logic            i_err,
  input  logic [CH_W-1:0] i_err_ch,
  input  logic            i_spare_used,
  input  logic            i_clear,
  input  logic [CH_W-1:0] i_clear_ch,
  output logic            o_hit,
  output logic [CH_W-1:0] o_hit_ch,
  output logic            o_fatal
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ERR_THRESH);
  localparam logic [CH_W-1:0]  CH_LIM  = CH_W'(NUM_CH);

  logic [CNT_W-1:0] r_cnt [NUM_CH];
  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_nxt;
  logic             w_inc;

  always_comb begin
    w_cur = {CNT_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_err_ch == CH_W'(c)) w_cur = r_cnt[c];
    end
  end

  // Hit fires only on the increment that lands exactly on the threshold.
  assign w_nxt    = w_cur + CNT_W'(1);
  assign w_inc    = i_err && (i_err_ch < CH_LIM) && (w_cur != CNT_MAX);
  assign o_hit    = w_inc && (w_nxt == THRESH);
  assign o_hit_ch = i_err_ch;
  assign o_fatal  = o_hit && i_spare_used;

  always_ff @(posedge clk_2gt or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= {CNT_W{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_clear && (i_clear_ch == CH_W'(c))) r_cnt[c] <= {CNT_W{1'b0}};
        else if (w_inc && (i_err_ch == CH_W'(c))) r_cnt[c] <= w_nxt;
        else r_cnt[c] <= r_cnt[c];
      end
    end
  end

endmodule

// File: rtl/hbm_scrub_sched.sv
// HBM scrub scheduler: patrol/demand scrub interleaving and one-time hot-spare swap.
module hbm_scrub_sched
  import hbm_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int CH_W           = CH_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int ERR_THRESH     = 4,
  parameter int CNT_W          = 8
) (
  input  logic              clk_2gt,
  input  logic              rst,
  input  logic              ecc_error,
  input  logic [CH_W-1:0]   ecc_ch,
  input  logic [ADDR_W-1:0] ecc_addr,
  output logic              scrub_req,
  output logic [CH_W-1:0]   scrub_ch,
  output logic [ADDR_W-1:0] scrub_addr,
  input  logic              scrub_ack,
  output logic              swap_req,
  output logic [CH_W-1:0]   swap_ch,
  input  logic              swap_done,
  output logic              veto,
  output logic              spare_used,
  output logic [CH_W-1:0]   spare_map,
  output logic              pass_done,
  output logic              demand_drop,
  output logic              err_fatal
);

  localparam int                IW         = $clog2(SCRUB_INTERVAL);
  localparam logic [IW-1:0]     INT_RELOAD = IW'(SCRUB_INTERVAL - 1);
  localparam logic [CH_W-1:0]   SPARE_IDX  = CH_W'(NUM_CH);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};

  sched_state_e      r_state, w_state_nxt;
  logic [IW-1:0]     r_int_cnt;
  logic              r_patrol_pending;
  logic              r_dem_valid;
  logic [CH_W-1:0]   r_dem_ch;
  logic [ADDR_W-1:0] r_dem_addr;
  logic [CH_W-1:0]   r_patrol_ch;
  logic [ADDR_W-1:0] r_patrol_addr;
  logic              r_scrub_req, r_scrub_dem;
  logic [CH_W-1:0]   r_scrub_ch;
  logic [ADDR_W-1:0] r_scrub_addr;
  logic              r_swap_req, r_veto, r_swap_pending, r_spare_used;
  logic [CH_W-1:0]   r_swap_ch, r_spare_map;
  logic              r_pass_done, r_demand_drop, r_err_fatal;

  logic              w_scrub_req_nxt, w_scrub_dem_nxt, w_swap_req_nxt, w_veto_nxt;
  logic [CH_W-1:0]   w_scrub_ch_nxt;
  logic [ADDR_W-1:0] w_scrub_addr_nxt;
  logic              w_ack_dem, w_ack_pat, w_swap_fin, w_tick, w_dem_free;
  logic              w_hit, w_fatal;
  logic [CH_W-1:0]   w_hit_ch;

  function automatic logic [CH_W-1:0] map_ch(input logic [CH_W-1:0] ch, input logic used,
                                              input logic [CH_W-1:0] map);
    return (used && (ch == map)) ? SPARE_IDX : ch;
  endfunction

  hbm_err_tracker #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .ERR_THRESH(ERR_THRESH)
  ) u_err_tracker (
    .clk_2gt     (clk_2gt),
    .rst         (rst),
    .i_err       (ecc_error),
    .i_err_ch    (ecc_ch),
    .i_spare_used(r_spare_used),
    .i_clear     (w_swap_fin),
    .i_clear_ch  (r_swap_ch),
    .o_hit       (w_hit),
    .o_hit_ch    (w_hit_ch),
    .o_fatal     (w_fatal)
  );

  assign w_tick     = (r_int_cnt == {IW{1'b0}});
  assign w_dem_free = !r_dem_valid || w_ack_dem;

  always_comb begin
    w_state_nxt      = r_state;
    w_scrub_req_nxt  = r_scrub_req;
    w_scrub_ch_nxt   = r_scrub_ch;
    w_scrub_addr_nxt = r_scrub_addr;
    w_scrub_dem_nxt  = r_scrub_dem;
    w_swap_req_nxt   = r_swap_req;
    w_veto_nxt       = r_veto;
    w_ack_dem        = 1'b0;
    w_ack_pat        = 1'b0;
    w_swap_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_swap_pending) begin
          w_state_nxt    = ST_SWAP;
          w_swap_req_nxt = 1'b1;
          w_veto_nxt     = 1'b1;
        end else if (r_dem_valid) begin
          w_state_nxt      = ST_SCRUB;
          w_scrub_req_nxt  = 1'b1;
          w_scrub_ch_nxt   = map_ch(r_dem_ch, r_spare_used, r_spare_map);
          w_scrub_addr_nxt = r_dem_addr;
          w_scrub_dem_nxt  = 1'b1;
        end else if (r_patrol_pending) begin
          w_state_nxt      = ST_SCRUB;
          w_scrub_req_nxt  = 1'b1;
          w_scrub_ch_nxt   = map_ch(r_patrol_ch, r_spare_used, r_spare_map);
          w_scrub_addr_nxt = r_patrol_addr;
          w_scrub_dem_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCRUB: begin
        if (scrub_ack) begin
          w_state_nxt     = ST_IDLE;
          w_scrub_req_nxt = 1'b0;
          w_ack_dem       = r_scrub_dem;
          w_ack_pat       = !r_scrub_dem;
        end else begin
          w_state_nxt = ST_SCRUB;
        end
      end
      ST_SWAP: begin
        if (swap_done) begin
          w_state_nxt    = ST_IDLE;
          w_swap_req_nxt = 1'b0;
          w_veto_nxt     = 1'b0;
          w_swap_fin     = 1'b1;
        end else begin
          w_state_nxt = ST_SWAP;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_scrub_req_nxt = 1'b0;
        w_swap_req_nxt  = 1'b0;
        w_veto_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_2gt or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_2gt or posedge rst) begin
    if (rst) begin
      r_scrub_req  <= 1'b0;
      r_scrub_ch   <= {CH_W{1'b0}};
      r_scrub_addr <= {ADDR_W{1'b0}};
      r_scrub_dem  <= 1'b0;
      r_swap_req   <= 1'b0;
      r_veto       <= 1'b0;
    end else begin
      r_scrub_req  <= w_scrub_req_nxt;
      r_scrub_ch   <= w_scrub_ch_nxt;
      r_scrub_addr <= w_scrub_addr_nxt;
      r_scrub_dem  <= w_scrub_dem_nxt;
      r_swap_req   <= w_swap_req_nxt;
      r_veto       <= w_veto_nxt;
    end
  end

  // A new interval tick outranks the ack of the previous patrol.
  always_ff @(posedge clk_2gt or posedge rst) begin
    if (rst) begin
      r_int_cnt        <= INT_RELOAD;
      r_patrol_pending <= 1'b0;
    end else begin
      r_int_cnt <= w_tick ? INT_RELOAD : (r_int_cnt - IW'(1));
      if (w_tick)         r_patrol_pending <= 1'b1;
      else if (w_ack_pat) r_patrol_pending <= 1'b0;
      else                r_patrol_pending <= r_patrol_pending;
    end
  end

  always_ff @(posedge clk_2gt or posedge rst) begin
    if (rst) begin
      r_dem_valid   <= 1'b0;
      r_dem_ch      <= {CH_W{1'b0}};
      r_dem_addr    <= {ADDR_W{1'b0}};
      r_demand_drop <= 1'b0;
    end else begin
      r_demand_drop <= ecc_error && !w_dem_free;
      if (ecc_error && w_dem_free) begin
        r_dem_valid <= 1'b1;
        r_dem_ch    <= ecc_ch;
        r_dem_addr  <= ecc_addr;
      end else if (w_ack_dem) begin
        r_dem_valid <= 1'b0;
      end else begin
        r_dem_valid <= r_dem_valid;
      end
    end
  end

  always_ff @(posedge clk_2gt or posedge rst) begin
    if (rst) begin
      r_patrol_ch   <= {CH_W{1'b0}};
      r_patrol_addr <= {ADDR_W{1'b0}};
      r_pass_done   <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      if (w_ack_pat) begin
        if (r_patrol_addr == ADDR_MAX) begin
          r_patrol_addr <= {ADDR_W{1'b0}};
          if (r_patrol_ch == LAST_CH) begin
            r_patrol_ch <= {CH_W{1'b0}};
            r_pass_done <= 1'b1;
          end else begin
            r_patrol_ch <= r_patrol_ch + CH_W'(1);
          end
        end else begin
          r_patrol_addr <= r_patrol_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_2gt or posedge rst) begin
    if (rst) begin
      r_swap_pending <= 1'b0;
      r_swap_ch      <= {CH_W{1'b0}};
      r_spare_used   <= 1'b0;
      r_spare_map    <= {CH_W{1'b0}};
      r_err_fatal    <= 1'b0;
    end else begin
      if (w_swap_fin) begin
        r_swap_pending <= 1'b0;
        r_spare_used   <= 1'b1;
        r_spare_map    <= r_swap_ch;
      end else if (w_hit && !r_spare_used && !r_swap_pending) begin
        r_swap_pending <= 1'b1;
        r_swap_ch      <= w_hit_ch;
      end
      if (w_fatal) r_err_fatal <= 1'b1;
    end
  end

  assign scrub_req   = r_scrub_req;
  assign scrub_ch    = r_scrub_ch;
  assign scrub_addr  = r_scrub_addr;
  assign swap_req    = r_swap_req;
  assign swap_ch     = r_swap_ch;
  assign veto        = r_veto;
  assign spare_used  = r_spare_used;
  assign spare_map   = r_spare_map;
  assign pass_done   = r_pass_done;
  assign demand_drop = r_demand_drop;
  assign err_fatal   = r_err_fatal;

endmodule

// File: tb/tb_hbm_scrub_sched.sv
// Bench for hbm_scrub_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_hbm_scrub_sched;
  import hbm_pkg::*;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 4;
  localparam int ADDR_W = 4;
  localparam int SI     = 16;
  localparam int TH     = 4;
  localparam int CNT_W  = 8;
  localparam int ROWS   = 1 << ADDR_W;
  localparam int NPOS   = NUM_CH * ROWS;

  logic clk_2gt = 1'b0;
  logic rst;
  logic ecc_error, scrub_ack, swap_done;
  logic [CH_W-1:0] ecc_ch;
  logic [ADDR_W-1:0] ecc_addr;
  logic scrub_req, swap_req, veto, spare_used, pass_done, demand_drop, err_fatal;
  logic [CH_W-1:0] scrub_ch, swap_ch, spare_map;
  logic [ADDR_W-1:0] scrub_addr;

  int total = 0;
  int bad = 0;
  int cy = 0;
  int saw_pass = 0;
  int saw_spare = 0;

  hbm_scrub_sched #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W),
    .SCRUB_INTERVAL(SI), .ERR_THRESH(TH), .CNT_W(CNT_W)
  ) dut (
    .clk_2gt(clk_2gt), .rst(rst),
    .ecc_error(ecc_error), .ecc_ch(ecc_ch), .ecc_addr(ecc_addr),
    .scrub_req(scrub_req), .scrub_ch(scrub_ch), .scrub_addr(scrub_addr), .scrub_ack(scrub_ack),
    .swap_req(swap_req), .swap_ch(swap_ch), .swap_done(swap_done), .veto(veto),
    .spare_used(spare_used), .spare_map(spare_map), .pass_done(pass_done),
    .demand_drop(demand_drop), .err_fatal(err_fatal)
  );

  always #5 clk_2gt = ~clk_2gt;

  // Model state: mode 0 idle, 1 scrubbing, 2 swapping; patrol position is one linear row index.
  int m_mode, m_cyc, m_pos, m_swch, m_map, m_sch, m_saddr;
  bit m_pp, m_swp, m_spare, m_fatal, m_sreq, m_sdem, m_wreq, m_veto, m_pass, m_drop;
  int m_cnt [NUM_CH];
  scrub_req_t m_dq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_pos = 0; m_swch = 0; m_map = 0; m_sch = 0; m_saddr = 0;
    m_pp = 0; m_swp = 0; m_spare = 0; m_fatal = 0; m_sreq = 0; m_sdem = 0;
    m_wreq = 0; m_veto = 0; m_pass = 0; m_drop = 0;
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    m_dq.delete();
  endtask

  function automatic int redir(input int ch, input bit used, input int map);
    return (used && ch == map) ? SPARE_CH : ch;
  endfunction

  task automatic model_step();
    bit ack_dem, ack_pat, fin, o_swp, o_spare, o_pp;
    int o_map, o_pos, o_dqn, o_swch, ch;
    scrub_req_t o_head, ent;
    ack_dem = (m_mode == 1) && scrub_ack && m_sdem;
    ack_pat = (m_mode == 1) && scrub_ack && !m_sdem;
    fin = (m_mode == 2) && swap_done;
    o_swp = m_swp; o_spare = m_spare; o_map = m_map; o_pp = m_pp; o_pos = m_pos;
    o_swch = m_swch; o_dqn = m_dq.size();
    o_head = '0;
    if (o_dqn > 0) o_head = m_dq[0];
    m_cyc++;
    if (ack_pat) m_pp = 0;
    if (m_cyc % SI == 0) m_pp = 1;
    if (ack_dem) void'(m_dq.pop_front());
    m_drop = 0;
    if (ecc_error) begin
      ent.ch = ecc_ch;
      ent.addr = 16'(ecc_addr);
      if (m_dq.size() == 0) m_dq.push_back(ent);
      else m_drop = 1;
    end
    ch = int'(ecc_ch);
    if (ecc_error && ch < NUM_CH && m_cnt[ch] < 255) begin
      m_cnt[ch]++;
      if (m_cnt[ch] == TH) begin
        if (o_spare) m_fatal = 1;
        else if (!o_swp) begin m_swp = 1; m_swch = ch; end
      end
    end
    if (fin) m_cnt[o_swch] = 0;
    m_pass = 0;
    if (ack_pat) begin
      m_pos = (m_pos + 1) % NPOS;
      if (m_pos == 0) m_pass = 1;
    end
    case (m_mode)
      0: begin
        if (o_swp) begin
          m_mode = 2; m_wreq = 1; m_veto = 1;
        end else if (o_dqn > 0) begin
          m_mode = 1; m_sreq = 1; m_sdem = 1;
          m_sch = redir(int'(o_head.ch), o_spare, o_map); m_saddr = int'(o_head.addr);
        end else if (o_pp) begin
          m_mode = 1; m_sreq = 1; m_sdem = 0;
          m_sch = redir(o_pos / ROWS, o_spare, o_map); m_saddr = o_pos % ROWS;
        end
      end
      1: if (scrub_ack) begin m_mode = 0; m_sreq = 0; end
      2: if (swap_done) begin
        m_mode = 0; m_wreq = 0; m_veto = 0; m_spare = 1; m_map = o_swch; m_swp = 0;
      end
      default: m_mode = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk_2gt);
    if (rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk_2gt);
    chk("scrub_req", scrub_req, m_sreq);
    if (m_sreq) begin
      chk("scrub_ch", scrub_ch, m_sch);
      chk("scrub_addr", scrub_addr, m_saddr);
    end
    chk("swap_req", swap_req, m_wreq);
    if (m_wreq) chk("swap_ch", swap_ch, m_swch);
    chk("veto", veto, m_veto);
    chk("spare_used", spare_used, m_spare);
    if (m_spare) chk("spare_map", spare_map, m_map);
    chk("pass_done", pass_done, m_pass);
    chk("demand_drop", demand_drop, m_drop);
    chk("err_fatal", err_fatal, m_fatal);
  end

  task automatic cyc();
    @(posedge clk_2gt);
    #1;
    cy++;
    ecc_error = 1'b0;
    swap_done = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cy < n) cyc();
  endtask

  task automatic inject(input int ch, input int addr);
    ecc_error = 1'b1;
    ecc_ch = ch[CH_W-1:0];
    ecc_addr = addr[ADDR_W-1:0];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sreq"}, scrub_req, 0);
    chk({tag, "_sch"}, scrub_ch, 0);
    chk({tag, "_saddr"}, scrub_addr, 0);
    chk({tag, "_wreq"}, swap_req, 0);
    chk({tag, "_wch"}, swap_ch, 0);
    chk({tag, "_veto"}, veto, 0);
    chk({tag, "_spare"}, spare_used, 0);
    chk({tag, "_map"}, spare_map, 0);
    chk({tag, "_pass"}, pass_done, 0);
    chk({tag, "_drop"}, demand_drop, 0);
    chk({tag, "_fatal"}, err_fatal, 0);
  endtask

  task automatic rand_run(input int n, input int err_mod, input int done_mod);
    for (int i = 0; i < n; i++) begin
      cyc();
      scrub_ack = ($urandom_range(7, 0) != 0);
      if ($urandom_range(err_mod - 1, 0) == 0) inject($urandom_range(NUM_CH, 0), $urandom_range(ROWS - 1, 0));
      swap_done = ($urandom_range(done_mod - 1, 0) == 0);
      if (pass_done) saw_pass++;
      if (scrub_req && scrub_ch == CH_W'(SPARE_CH)) saw_spare++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ecc_error = 1'b0; ecc_ch = '0; ecc_addr = '0; scrub_ack = 1'b1; swap_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_2gt);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    cy = 0;

    // Patrol cadence: request at 17, 33, 49 with rows 0,1,2 of channel 0.
    for (int i = 1; i <= 50; i++) begin
      cyc();
      chk("cad_req", scrub_req, (cy == 17 || cy == 33 || cy == 49));
      if (scrub_req) begin
        chk("cad_ch", scrub_ch, 0);
        chk("cad_addr", scrub_addr, (cy - 17) / 16);
      end
    end

    // Demand and patrol pending set on the same edge: demand goes first.
    run_to(63); inject(3, 10);
    cyc(); cyc();
    chk("prio_req", scrub_req, 1); chk("prio_ch", scrub_ch, 3); chk("prio_addr", scrub_addr, 10);
    cyc(); chk("prio_gap", scrub_req, 0);
    cyc(); chk("prio_pat_req", scrub_req, 1); chk("prio_pat_ch", scrub_ch, 0); chk("prio_pat_addr", scrub_addr, 3);

    // Buffer overflow with ack withheld.
    run_to(70); scrub_ack = 1'b0; inject(6, 1);
    cyc(); inject(6, 2);
    cyc(); chk("ovf_drop", demand_drop, 1); chk("ovf_ch", scrub_ch, 6); chk("ovf_addr", scrub_addr, 1);
    cyc(); chk("ovf_drop_once", demand_drop, 0);
    run_to(85); chk("ovf_hold_req", scrub_req, 1); chk("ovf_hold_addr", scrub_addr, 1);
    scrub_ack = 1'b1;
    cyc(); cyc(); chk("ovf_pat_addr", scrub_addr, 4);

    // Four errors on channel 5 trigger the swap.
    for (int k = 0; k < 4; k++) begin
      run_to(90 + 2 * k); inject(5, 7 + k);
    end
    run_to(98);
    chk("swap_req", swap_req, 1); chk("swap_veto", veto, 1); chk("swap_ch5", swap_ch, 5); chk("swap_noscrub", scrub_req, 0);
    run_to(108); chk("swap_hold", swap_req, 1); chk("swap_hold_noscrub", scrub_req, 0);
    swap_done = 1'b1;
    cyc(); chk("swap_fin_req", swap_req, 0); chk("swap_fin_veto", veto, 0);
    chk("swap_spare", spare_used, 1); chk("swap_map", spare_map, 5);
    cyc(); chk("redir_req", scrub_req, 1); chk("redir_ch", scrub_ch, SPARE_CH); chk("redir_addr", scrub_addr, 10);

    // Threshold again after the spare is gone.
    for (int k = 0; k < 4; k++) begin
      run_to(120 + 3 * k); inject(2, k);
    end
    run_to(132); chk("fatal", err_fatal, 1); chk("fatal_noswap", swap_req, 0);

    rand_run(3000, 50, 10);
    chk("saw_pass", (saw_pass > 0), 1);
    chk("saw_spare", (saw_spare > 0), 1);

    // Reset in the middle of a swap.
    rst = 1'b1; model_reset();
    cyc(); cyc();
    rst = 1'b0; cy = 0; scrub_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_to(2 + 2 * k); inject(1, k);
    end
    begin
      int k;
      k = 0;
      while (!swap_req && k < 30) begin cyc(); k++; end
      chk("rst_swap_seen", swap_req, 1);
    end
    rst = 1'b1; model_reset();
    #1;
    chk_all_zero("rst_mid");
    cyc(); cyc();
    rst = 1'b0; cy = 0;
    swap_done = 1'b1;
    cyc(); cyc();
    chk("rst_done_ign_req", swap_req, 0); chk("rst_done_ign_spare", spare_used, 0); chk("rst_done_ign_veto", veto, 0);

    rand_run(5000, 10, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hbm_scrub_sched.md
Name: hbm_scrub_sched

Overview:
- Scheduler and controller for HBM channel scrubbing and hot-spare replacement.
- Sits between the ECC/patrol-scrub logic and the HBM controller.
- Interleaves periodic patrol scrubs with demand scrubs triggered by ECC errors.
- Keeps a per-channel error count. When a channel crosses threshold, sequences a one-time swap onto spare channel NUM_CH and raises veto for the swap's duration.

Parameters:
- NUM_CH, 8: active channels, 0..NUM_CH-1. The spare channel is index NUM_CH.
- CH_W, 4: channel index width. Must satisfy 2**CH_W > NUM_CH.
- ADDR_W, 16: scrub row address width.
- SCRUB_INTERVAL, 1024: cycles between patrol scrub issues. Must be >= 2.
- ERR_THRESH, 4: per-channel error count that triggers a swap. Range 1..2**CNT_W-1.
- CNT_W, 8: per-channel error counter width.

Ports:
- clk_2gt  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- ecc_error  in  1  single-cycle pulse: a correctable ECC error was detected.
- ecc_ch  in  CH_W  channel of the error; valid with ecc_error.
- ecc_addr  in  ADDR_W  row of the error; valid with ecc_error.
- scrub_req  out  1  scrub request to the HBM controller.
- scrub_ch  out  CH_W  channel to scrub; stable while scrub_req=1.
- scrub_addr  out  ADDR_W  row to scrub; stable while scrub_req=1.
- scrub_ack  in  1  controller accepts the scrub in the cycle scrub_req&scrub_ack.
- swap_req  out  1  request hot swap of swap_ch onto the spare.
- swap_ch  out  CH_W  failing channel; stable while swap_req=1.
- swap_done  in  1  single-cycle pulse: the swap is complete.
- veto  out  1  high from swap_req assertion through the swap_done cycle.
- spare_used  out  1  sticky: the spare channel is allocated.
- spare_map  out  CH_W  channel replaced by the spare; valid when spare_used=1.
- pass_done  out  1  single-cycle pulse when a full patrol pass wraps.
- demand_drop  out  1  single-cycle pulse when a demand scrub is dropped because the buffer is full.
- err_fatal  out  1  sticky: threshold reached while spare_used=1.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Interval counter = SCRUB_INTERVAL-1.
  - Patrol channel and address = 0.
  - All error counters = 0.
  - Demand buffer and swap_pending empty.
- Interval counter:
  - Decrements every cycle.
  - At 0 it reloads SCRUB_INTERVAL-1 and sets patrol_pending.
  - Setting an already-set patrol_pending is a no-op; no accumulation.
- Demand buffer (one entry, {ch, addr}):
  - ecc_error with the buffer empty loads the entry.
  - ecc_error with the buffer full drops the error and pulses demand_drop the next cycle.
  - The error counter still increments when the scrub is dropped.
- Error counters:
  - On ecc_error with ecc_ch < NUM_CH, counter[ecc_ch] saturating-increments.
  - When the incremented value == ERR_THRESH and spare_used=0 and swap_pending=0: set swap_pending and latch swap_ch.
  - When the threshold is reached with spare_used=1: set err_fatal.
  - ecc_ch >= NUM_CH, i.e. an error on the spare: only loads the demand buffer; no counting.
- Patrol channel redirect:
  - When spare_used=1, a patrol target equal to spare_map is issued as scrub_ch=NUM_CH.
  - Demand scrubs to spare_map are redirected the same way.
- FSM states: IDLE, SCRUB, SWAP.
  - IDLE: priority is swap_pending, then demand buffer, then patrol_pending.
    - swap_pending -> SWAP: swap_req=1, veto=1.
    - Demand -> SCRUB with the buffer entry.
    - Patrol -> SCRUB with the patrol channel and address.
    - All outputs are registered; scrub_req rises the cycle after the decision.
  - SCRUB: hold scrub_req, scrub_ch and scrub_addr until scrub_ack, then return to IDLE and deassert scrub_req that cycle.
    - Demand ack: clear the demand buffer.
    - Patrol ack: clear patrol_pending; address+1.
    - Address wrap 2**ADDR_W-1 -> 0: channel+1.
    - Channel wrap NUM_CH-1 -> 0 together with address wrap: pulse pass_done.
    - A new swap_pending never preempts an outstanding scrub.
  - SWAP: hold swap_req and veto until swap_done, then in the same edge:
    - swap_req=0 and veto=0.
    - spare_used=1, spare_map=swap_ch.
    - counter[swap_ch]=0, swap_pending=0.
    - Return to IDLE.
    - Scrub requests are suppressed in SWAP. ECC counting and interval counting continue.
- Ignored inputs:
  - swap_done outside SWAP is ignored.
  - scrub_ack outside SCRUB is ignored.
- Simultaneous events:
  - An ecc_error in the same cycle as a demand-scrub ack is accepted, because the buffer frees that edge.
- Reset mid-operation: immediate return to reset values, including clearing spare_used and err_fatal.

Decomposition:
- Shared package hbm_pkg:
  - FSM state enum.
  - NUM_CH/CH_W defaults.
  - SPARE_CH constant = NUM_CH.
  - Scrub request struct {ch, addr}.
- One sub-module, hbm_err_tracker:
  - Holds the per-channel saturating counters and the threshold compare.
  - Outputs hit, hit_ch, fatal.
  - Takes a clear input with clear_ch.
- Top level: FSM, interval counter, demand buffer, patrol walker.

Test Plan:
- Patrol cadence: SCRUB_INTERVAL=16, scrub_ack tied 1, no errors -> scrub_req every 16 cycles; addresses 0,1,2 on channel 0.
- Demand priority: ecc_error ch=3 addr=0x55 in the same cycle patrol_pending sets -> first scrub is {3,0x55}, next is the patrol {0,0}.
- Demand overflow: scrub_ack held 0, two ecc_error pulses -> second pulse drops; demand_drop pulses once; counter[ch]=2.
- Swap sequence: 4 errors on ch 5, ERR_THRESH=4 -> swap_req=1 and veto=1 with swap_ch=5 after the pending scrub acks.
  - swap_done -> spare_used=1, spare_map=5, veto=0.
  - Later patrol of ch 5 issues scrub_ch=8.
- Fatal: after the swap, 4 errors on ch 2 -> err_fatal=1 and no swap_req.
- Reset mid-SWAP: rst pulse while swap_req=1 -> all outputs 0 immediately; a subsequent swap_done is ignored.
